// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: shares the single data-memory port between the two LSU
// lanes of a dual-issue bundle. Lane 0 is always served before lane 1, so
// same-address store->load pairs within a bundle are coherent. The backend
// is stalled until every valid lane of the bundle has completed.
//
// Ports:
//   clock_i, reset_n_i          clock, asynchronous active-low reset
//   backend_we_i                pipeline advance; starts a new bundle
//   ldN_i/stN_i/addrN_i/...     per-lane access (N = 0, 1)
//   mem_stall_o                 stall request, combinational from flags/lanes
//   rdataN_o                    aligned, extended load data per lane
//   misalign_o                  one-cycle pulse per misaligned/illegal lane
//   dmem_*                      request/grant/response memory port
module lsu_mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              backend_we_i,
    input  logic              ld0_i,
    input  logic              st0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [31:0]       wdata0_i,
    input  logic [1:0]        size0_i,
    input  logic              unsigned0_i,
    input  logic              ld1_i,
    input  logic              st1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [31:0]       wdata1_i,
    input  logic [1:0]        size1_i,
    input  logic              unsigned1_i,
    output logic              mem_stall_o,
    output logic [31:0]       rdata0_o,
    output logic [31:0]       rdata1_o,
    output logic [1:0]        misalign_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i
);

    typedef enum logic [2:0] {IDLE = 3'd0, REQ0, WAIT0, REQ1, WAIT1} state_t;

    state_t      state;
    logic [1:0]  done;
    logic [1:0]  lsize;   // size/offset/sign of the in-flight load, for alignment
    logic [1:0]  loff;
    logic        luns;

    function automatic logic is_bad(logic ld, logic st, logic [1:0] size, logic [1:0] off);
        return (ld & st) | (size == 2'b11) | ((size == 2'b01) & off[0]) |
               ((size == 2'b10) & (off != 2'b00));
    endfunction

    function automatic logic [3:0] be_of(logic [1:0] size, logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_of(logic [1:0] size, logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] align(logic [31:0] d, logic [1:0] off,
                                          logic [1:0] size, logic uns);
        logic [31:0] sh;
        sh = d >> {off, 3'b000};
        case (size)
            2'b00:   return uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    logic              v0, v1;
    logic              sel1;      // lane chosen from IDLE: lane 0 unless it is done/idle
    logic              s_ld, s_st, s_uns, s_bad;
    logic [ADDR_W-1:0] s_addr;
    logic [31:0]       s_wdata;
    logic [1:0]        s_size;
    logic              cur1;      // lane owning the current REQ/WAIT state

    assign v0          = ld0_i | st0_i;
    assign v1          = ld1_i | st1_i;
    assign mem_stall_o = (v0 & ~done[0]) | (v1 & ~done[1]);
    assign sel1        = ~(v0 & ~done[0]);
    assign s_ld        = sel1 ? ld1_i       : ld0_i;
    assign s_st        = sel1 ? st1_i       : st0_i;
    assign s_uns       = sel1 ? unsigned1_i : unsigned0_i;
    assign s_addr      = sel1 ? addr1_i     : addr0_i;
    assign s_wdata     = sel1 ? wdata1_i    : wdata0_i;
    assign s_size      = sel1 ? size1_i     : size0_i;
    assign s_bad       = is_bad(s_ld, s_st, s_size, s_addr[1:0]);
    assign cur1        = (state == REQ1) || (state == WAIT1);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            done         <= 2'b00;
            lsize        <= 2'b00;
            loff         <= 2'b00;
            luns         <= 1'b0;
            rdata0_o     <= 32'b0;
            rdata1_o     <= 32'b0;
            misalign_o   <= 2'b00;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= 4'b0;
            dmem_wdata_o <= 32'b0;
        end else begin
            misalign_o <= 2'b00;
            case (state)
                IDLE: begin
                    // the stall term is exactly "some valid lane not yet done"
                    if (mem_stall_o) begin
                        if (s_bad) begin
                            done[sel1]       <= 1'b1;
                            misalign_o[sel1] <= 1'b1;
                        end else begin
                            state        <= sel1 ? REQ1 : REQ0;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= s_st;
                            dmem_addr_o  <= {s_addr[ADDR_W-1:2], 2'b00};
                            dmem_be_o    <= be_of(s_size, s_addr[1:0]);
                            dmem_wdata_o <= wdata_of(s_size, s_wdata);
                            lsize        <= s_size;
                            loff         <= s_addr[1:0];
                            luns         <= s_uns;
                        end
                    end
                end
                REQ0, REQ1: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        dmem_we_o  <= 1'b0;
                        if (dmem_we_o) begin
                            done[cur1] <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state <= cur1 ? WAIT1 : WAIT0;
                        end
                    end
                end
                WAIT0, WAIT1: begin
                    if (dmem_rvalid_i) begin
                        if (cur1) rdata1_o <= align(dmem_rdata_i, loff, lsize, luns);
                        else      rdata0_o <= align(dmem_rdata_i, loff, lsize, luns);
                        done[cur1] <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // a new bundle starts with both lanes outstanding
            if (backend_we_i) begin
                done       <= 2'b00;
                misalign_o <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
module tb_lsu_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, backend_we;
    logic        ld0, st0, uns0, ld1, st1, uns1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  size0, size1;
    logic        mem_stall;
    logic [31:0] rdata0, rdata1;
    logic [1:0]  misalign;
    logic        req, we;
    logic [31:0] maddr, mwdata;
    logic [3:0]  be;
    logic        gnt, rvalid;
    logic [31:0] rdata;

    lsu_mem_arbiter #(.ADDR_W(32)) dut (
        .clock_i(clk), .reset_n_i(rst_n), .backend_we_i(backend_we),
        .ld0_i(ld0), .st0_i(st0), .addr0_i(addr0), .wdata0_i(wdata0),
        .size0_i(size0), .unsigned0_i(uns0),
        .ld1_i(ld1), .st1_i(st1), .addr1_i(addr1), .wdata1_i(wdata1),
        .size1_i(size1), .unsigned1_i(uns1),
        .mem_stall_o(mem_stall), .rdata0_o(rdata0), .rdata1_o(rdata1),
        .misalign_o(misalign), .dmem_req_o(req), .dmem_we_o(we),
        .dmem_addr_o(maddr), .dmem_be_o(be), .dmem_wdata_o(mwdata),
        .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          lane;
        logic [31:0] exp;
    } req_t;

    req_t        exp_q[$];
    logic [31:0] mem [int unsigned];
    int          n_chk = 0, n_fail = 0;
    int          hold_cnt = 0;
    bit          mute = 0, inject = 0, pend_rd = 0, chk_rd = 0, last_stall = 0;
    int          pend_lane = 0, rd_lane = 0, mis_cycles = 0;
    logic [31:0] pend_word = 0, pend_exp = 0, rd_exp = 0, inj_data = 0;
    logic [1:0]  mis_or = 0;

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // memory slave + scoreboard, evaluated mid-cycle
    task automatic monitor();
        req_t        e;
        logic [31:0] w;
        int unsigned k;
        if (backend_we) check("we_idle", 32'(dut.state), 32'd0);
        if (chk_rd) begin
            chk_rd = 0;
            if (rd_lane == 1) check("rdata1", rdata1, rd_exp);
            else              check("rdata0", rdata0, rd_exp);
        end
        rvalid = 1'b0;
        rdata  = 32'h0;
        if (pend_rd) begin
            pend_rd = 0;
            if (!mute) begin
                rvalid = 1'b1; rdata = pend_word;
                chk_rd = 1; rd_lane = pend_lane; rd_exp = pend_exp;
            end
        end
        if (inject) begin
            inject = 0; rvalid = 1'b1; rdata = inj_data;
        end
        gnt = 1'b0;
        if (req) begin
            if (exp_q.size() == 0) begin
                check("unexp_req", 32'(req), 32'd0);
            end else begin
                e = exp_q[0];
                check("req_we", 32'(we), 32'(e.we));
                check("req_addr", maddr, e.addr);
                check("req_be", 32'(be), 32'(e.be));
                if (e.we) check("req_wdata", mwdata, e.wdata);
                if (hold_cnt > 0) begin
                    hold_cnt--;
                end else begin
                    gnt = 1'b1;
                    void'(exp_q.pop_front());
                    k = e.addr >> 2;
                    w = mem.exists(k) ? mem[k] : 32'h0;
                    if (e.we) begin
                        for (int i = 0; i < 4; i++)
                            if (e.be[i]) w[8*i +: 8] = e.wdata[8*i +: 8];
                        mem[k] = w;
                    end else begin
                        pend_rd = 1; pend_word = w; pend_lane = e.lane; pend_exp = e.exp;
                    end
                end
            end
        end
        last_stall = mem_stall;
        if (misalign != 2'b00) begin
            mis_cycles++;
            mis_or |= misalign;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(int n, bit ld, bit st, logic [31:0] a, logic [31:0] d,
                            logic [1:0] sz, bit u);
        if (n == 0) begin ld0 = ld; st0 = st; addr0 = a; wdata0 = d; size0 = sz; uns0 = u; end
        else        begin ld1 = ld; st1 = st; addr1 = a; wdata1 = d; size1 = sz; uns1 = u; end
    endtask

    task automatic expect_req(bit w, logic [31:0] a, logic [3:0] b, logic [31:0] d,
                              int lane, logic [31:0] exp);
        req_t e;
        e.we = w; e.addr = a; e.be = b; e.wdata = d; e.lane = lane; e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic start();
        backend_we = 1'b1;
        ld0 = 0; st0 = 0; ld1 = 0; st1 = 0;
        tick();
        backend_we = 1'b0;
    endtask

    task automatic run_bundle(string tag, int exp_stall, logic [1:0] exp_mis);
        int n = 0;
        mis_cycles = 0;
        mis_or     = 2'b00;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!last_stall) break;
            n++;
        end
        tick();
        check({tag, "_stall"}, 32'(n), 32'(exp_stall));
        check({tag, "_mis"}, 32'(mis_or), 32'(exp_mis));
        check({tag, "_mis_cyc"}, 32'(mis_cycles), (exp_mis != 2'b00) ? 32'd1 : 32'd0);
        check({tag, "_q"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_rd_pend"}, 32'(chk_rd), 32'd0);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_rdata0"}, rdata0, 32'h0);
        check({tag, "_rdata1"}, rdata1, 32'h0);
        check({tag, "_misalign"}, 32'(misalign), 32'h0);
        check({tag, "_req"}, 32'(req), 32'h0);
        check({tag, "_we"}, 32'(we), 32'h0);
        check({tag, "_addr"}, maddr, 32'h0);
        check({tag, "_be"}, 32'(be), 32'h0);
        check({tag, "_wdata"}, mwdata, 32'h0);
        check({tag, "_state"}, 32'(dut.state), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1);
    end

    initial begin
        rst_n = 0; backend_we = 0; gnt = 0; rvalid = 0; rdata = 0;
        set_lane(0, 0, 0, 0, 0, 0, 0);
        set_lane(1, 0, 0, 0, 0, 0, 0);
        mem[0] = 32'h80FFFFFF;
        mem[4] = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        check_zero("reset");
        check("reset_stall", 32'(mem_stall), 32'h0);
        @(posedge clk); #1;
        rst_n = 1;
        tick();

        // single word load
        start();
        set_lane(0, 1, 0, 32'h10, 0, 2'b10, 0);
        expect_req(0, 32'h10, 4'hF, 0, 0, 32'hDEADBEEF);
        run_bundle("lw", 3, 2'b00);

        // store then load same address, lane 0 first
        start();
        set_lane(0, 0, 1, 32'h20, 32'h11223344, 2'b10, 0);
        set_lane(1, 1, 0, 32'h20, 0, 2'b10, 0);
        expect_req(1, 32'h20, 4'hF, 32'h11223344, 0, 0);
        expect_req(0, 32'h20, 4'hF, 0, 1, 32'h11223344);
        run_bundle("sw_lw", 5, 2'b00);

        // signed / unsigned byte at offset 3
        start();
        set_lane(0, 1, 0, 32'h3, 0, 2'b00, 0);
        expect_req(0, 32'h0, 4'b1000, 0, 0, 32'hFFFFFF80);
        run_bundle("lb", 3, 2'b00);
        start();
        set_lane(1, 1, 0, 32'h3, 0, 2'b00, 1);
        expect_req(0, 32'h0, 4'b1000, 0, 1, 32'h00000080);
        run_bundle("lbu", 3, 2'b00);

        // misaligned word on lane 1: never reaches memory
        start();
        set_lane(1, 1, 0, 32'h6, 0, 2'b10, 0);
        run_bundle("mis1", 1, 2'b10);

        // grant withheld four cycles on a byte store
        start();
        hold_cnt = 4;
        set_lane(0, 0, 1, 32'h25, 32'h000000AB, 2'b00, 0);
        expect_req(1, 32'h24, 4'b0010, 32'hABABABAB, 0, 0);
        run_bundle("hold", 6, 2'b00);

        // dual load: word + signed half at offset 2
        start();
        set_lane(0, 1, 0, 32'h10, 0, 2'b10, 0);
        set_lane(1, 1, 0, 32'h22, 0, 2'b01, 0);
        expect_req(0, 32'h10, 4'hF, 0, 0, 32'hDEADBEEF);
        expect_req(0, 32'h20, 4'b1100, 0, 1, 32'h00001122);
        run_bundle("dual_lw", 6, 2'b00);

        // dual half loads, unsigned vs signed
        start();
        set_lane(0, 1, 0, 32'h2, 0, 2'b01, 1);
        set_lane(1, 1, 0, 32'h2, 0, 2'b01, 0);
        expect_req(0, 32'h0, 4'b1100, 0, 0, 32'h000080FF);
        expect_req(0, 32'h0, 4'b1100, 0, 1, 32'hFFFF80FF);
        run_bundle("dual_lh", 6, 2'b00);

        // illegal size on lane 0, lane 1 still served
        start();
        set_lane(0, 1, 0, 32'h10, 0, 2'b11, 0);
        set_lane(1, 1, 0, 32'h10, 0, 2'b10, 0);
        expect_req(0, 32'h10, 4'hF, 0, 1, 32'hDEADBEEF);
        run_bundle("mis0", 4, 2'b01);

        // reset while waiting for read data, then a stale rvalid
        start();
        mute = 1;
        set_lane(0, 1, 0, 32'h10, 0, 2'b10, 0);
        expect_req(0, 32'h10, 4'hF, 0, 0, 32'hDEADBEEF);
        tick(); tick(); tick();
        check("pre_rst_state", 32'(dut.state), 32'(3'd2));
        rst_n = 0;
        #1;
        check_zero("midrst");
        ld0 = 0;
        tick();
        rst_n = 1;
        tick();
        mute = 0;
        inj_data = 32'h12345678;
        inject = 1;
        tick(); tick();
        check_zero("stale");

        start();
        set_lane(0, 1, 0, 32'h10, 0, 2'b10, 0);
        expect_req(0, 32'h10, 4'hF, 0, 0, 32'hDEADBEEF);
        run_bundle("post_rst", 3, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
